// File: rtl/exec_output_arbiter.sv
// exec_output_arbiter
//
// Arbitrates between four execution units that want to hand a result to the
// memory stage. It uses a round-robin grant and a one-entry output register.
// A unit sees its canGo_o bit in the same cycle as its request. Its record
// appears on the *ToMem_o outputs one clock later and stays there until
// memReady_i accepts it. When the memory stage accepts the held record and a
// new grant happens in the same cycle, the new record replaces the old one, so
// the arbiter sustains one record per cycle.
//
// Optional feature (macro EXEC_ARB_STALL_CNT_EN):
//   adds stallCount_o, a saturating count of cycles in which a record was
//   held but not accepted. Reset and flush_i both clear it.
//
// Ports
//   clk_i             in   clock, rising edge
//   reset_i           in   asynchronous active-low reset
//   valid_i[3:0]      in   per-unit request
//   executeVal_i      in   per-unit 64-bit result
//   executeCommands_i in   per-unit 10-bit command
//   executeTag_i      in   per-unit ROB tag
//   executeFlags_i    in   per-unit 4-bit flags
//   canGo_o[3:0]      out  one-hot grant, combinational
//   memReady_i        in   memory stage accepts the held record
//   flush_i           in   synchronous flush, drops the held record
//   dataToMem_o       out  held record: data
//   commandsToMem_o   out  held record: commands
//   tagToMem_o        out  held record: tag
//   flagsToMem_o      out  held record: flags
//   stallCount_o      out  stall cycle count (only with EXEC_ARB_STALL_CNT_EN)
//   valid_o           out  held record is valid

module exec_output_arbiter #(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [3:0]                 valid_i,
  input  logic [3:0][63:0]           executeVal_i,
  input  logic [3:0][9:0]            executeCommands_i,
  input  logic [3:0][ROBsizeLog-1:0] executeTag_i,
  input  logic [3:0][3:0]            executeFlags_i,
  output logic [3:0]                 canGo_o,
  input  logic                       memReady_i,
  input  logic                       flush_i,
  output logic [63:0]                dataToMem_o,
  output logic [9:0]                 commandsToMem_o,
  output logic [ROBsizeLog-1:0]      tagToMem_o,
  output logic [3:0]                 flagsToMem_o,
`ifdef EXEC_ARB_STALL_CNT_EN
  output logic [15:0]                stallCount_o,
`endif
  output logic                       valid_o
);

  logic [1:0] rr_ptr;
  logic       load_ok;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [1:0] scan_idx;

  // Scan starts at rr_ptr and wraps around. Only the first valid unit wins.
  // Gating with reset_i keeps canGo_o low during reset, even while requesters
  // are still asserting valid_i.
  always_comb begin
    load_ok   = (!valid_o || memReady_i) && !flush_i;
    grant     = 4'b0000;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    if (load_ok && reset_i) begin
      for (int i = 0; i < 4; i++) begin
        scan_idx = rr_ptr + 2'(i);
        if (valid_i[scan_idx] && (grant == 4'b0000)) begin
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
        end
      end
    end
  end

  assign canGo_o = grant;

  // Every path that clears valid_o also clears the record fields. This is
  // what makes the outputs read zero whenever no record is held.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_o         <= 1'b0;
      dataToMem_o     <= '0;
      commandsToMem_o <= '0;
      tagToMem_o      <= '0;
      flagsToMem_o    <= '0;
      rr_ptr          <= 2'd0;
    end else if (flush_i) begin
      valid_o         <= 1'b0;
      dataToMem_o     <= '0;
      commandsToMem_o <= '0;
      tagToMem_o      <= '0;
      flagsToMem_o    <= '0;
    end else if (grant != 4'b0000) begin
      valid_o         <= 1'b1;
      dataToMem_o     <= executeVal_i[grant_idx];
      commandsToMem_o <= executeCommands_i[grant_idx];
      tagToMem_o      <= executeTag_i[grant_idx];
      flagsToMem_o    <= executeFlags_i[grant_idx];
      rr_ptr          <= grant_idx + 2'd1;
    end else if (valid_o && memReady_i) begin
      valid_o         <= 1'b0;
      dataToMem_o     <= '0;
      commandsToMem_o <= '0;
      tagToMem_o      <= '0;
      flagsToMem_o    <= '0;
    end
  end

`ifdef EXEC_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stallCount_o <= 16'h0000;
    end else if (flush_i) begin
      stallCount_o <= 16'h0000;
    end else if (valid_o && !memReady_i && (stallCount_o != 16'hFFFF)) begin
      stallCount_o <= stallCount_o + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_exec_output_arbiter.sv
// Bench for exec_output_arbiter. It keeps a reference model of the round-robin
// pointer and a queue that holds the record the output register should be
// holding. Grants observed at the falling edge are checked against the model.
// Register contents are checked 1 ns after the rising edge.

module tb_exec_output_arbiter;

  localparam int TW = 4;

  typedef struct {
    logic [63:0]   val;
    logic [9:0]    cmd;
    logic [TW-1:0] tag;
    logic [3:0]    flags;
  } rec_t;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic [3:0]         valid_i;
  logic [3:0][63:0]   executeVal_i;
  logic [3:0][9:0]    executeCommands_i;
  logic [3:0][TW-1:0] executeTag_i;
  logic [3:0][3:0]    executeFlags_i;
  logic [3:0]         canGo_o;
  logic               memReady_i;
  logic               flush_i;
  logic [63:0]        dataToMem_o;
  logic [9:0]         commandsToMem_o;
  logic [TW-1:0]      tagToMem_o;
  logic [3:0]         flagsToMem_o;
  logic               valid_o;
`ifdef EXEC_ARB_STALL_CNT_EN
  logic [15:0]        stallCount_o;
`endif

  exec_output_arbiter #(.ROBsize(8)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .valid_i           (valid_i),
    .executeVal_i      (executeVal_i),
    .executeCommands_i (executeCommands_i),
    .executeTag_i      (executeTag_i),
    .executeFlags_i    (executeFlags_i),
    .canGo_o           (canGo_o),
    .memReady_i        (memReady_i),
    .flush_i           (flush_i),
    .dataToMem_o       (dataToMem_o),
    .commandsToMem_o   (commandsToMem_o),
    .tagToMem_o        (tagToMem_o),
    .flagsToMem_o      (flagsToMem_o),
`ifdef EXEC_ARB_STALL_CNT_EN
    .stallCount_o      (stallCount_o),
`endif
    .valid_o           (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  rec_t       exp_q[$];
  logic [1:0] m_rr;
  logic [15:0] m_sc;
  logic [3:0] last_go;
  logic [3:0] go_seq [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    logic [1:0] k;
    g = 4'b0000;
    if (reset_i && ((exp_q.size() == 0) || memReady_i) && !flush_i) begin
      for (int i = 0; i < 4; i++) begin
        k = m_rr + 2'(i);
        if (valid_i[k] && (g == 4'b0000)) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic randomize_data();
    for (int u = 0; u < 4; u++) begin
      executeVal_i[u]      = {$urandom, $urandom};
      executeCommands_i[u] = 10'($urandom);
      executeTag_i[u]      = TW'($urandom);
      executeFlags_i[u]    = 4'($urandom);
    end
  endtask

  task automatic check_outputs();
    if (exp_q.size() > 0) begin
      check("valid_o", 64'(valid_o), 64'd1);
      check("data", dataToMem_o, exp_q[0].val);
      check("meta", 64'({commandsToMem_o, tagToMem_o, flagsToMem_o}),
            64'({exp_q[0].cmd, exp_q[0].tag, exp_q[0].flags}));
    end else begin
      check("valid_o", 64'(valid_o), 64'd0);
      check("data_zero", dataToMem_o, 64'd0);
      check("meta_zero", 64'({commandsToMem_o, tagToMem_o, flagsToMem_o}), 64'd0);
    end
`ifdef EXEC_ARB_STALL_CNT_EN
    check("stall_cnt", 64'(stallCount_o), 64'(m_sc));
`endif
  endtask

  // Inputs must already be set, one ns after a rising edge.
  task automatic step();
    logic [3:0] g;
    logic [1:0] k;
    rec_t       r;
    @(negedge clk_i);
    g = model_grant();
    last_go = canGo_o;
    check("can_go", 64'(canGo_o), 64'(g));
    if (flush_i) begin
      m_sc = 16'h0;
    end else if ((exp_q.size() > 0) && !memReady_i && (m_sc != 16'hFFFF)) begin
      m_sc = m_sc + 16'h1;
    end
    if (flush_i) begin
      exp_q.delete();
    end else begin
      if ((exp_q.size() > 0) && memReady_i) void'(exp_q.pop_front());
      if (g != 4'b0000) begin
        k       = onehot_idx(g);
        r.val   = executeVal_i[k];
        r.cmd   = executeCommands_i[k];
        r.tag   = executeTag_i[k];
        r.flags = executeFlags_i[k];
        exp_q.push_back(r);
        m_rr = k + 2'd1;
      end
    end
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rr = 2'd0;
    m_sc = 16'h0;
  endtask

  initial begin
    go_seq[0] = 4'b0001; go_seq[1] = 4'b0010; go_seq[2] = 4'b0100;
    go_seq[3] = 4'b1000; go_seq[4] = 4'b0001;
    reset_i    = 1'b0;
    valid_i    = 4'b1111;
    memReady_i = 1'b1;
    flush_i    = 1'b0;
    randomize_data();
    model_reset();

    // Reset: canGo_o stays low even with all requests up.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_can_go", 64'(canGo_o), 64'd0);
    check_outputs();
    reset_i = 1'b1;

    // All four requesting: grants rotate 0,1,2,3,0. Each tag shows up one cycle later.
    for (int u = 0; u < 4; u++) executeTag_i[u] = TW'(u + 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq", 64'(last_go), 64'(go_seq[i]));
    end
    check("rr_tag", 64'(tagToMem_o), 64'd1);

    // Single request from unit 2.
    valid_i = 4'b0100;
    executeVal_i[2] = 64'hDEAD_BEEF;
    step();
    check("beef_go", 64'(last_go), 64'(4'b0100));
    check("beef_data", dataToMem_o, 64'hDEAD_BEEF);
    valid_i = 4'b0000;
    step();
    check("beef_clear", dataToMem_o, 64'd0);

    // Back-pressure for 3 cycles, then resume.
    valid_i = 4'b0011;
    step();
    check("stall_pre_go", 64'(last_go), 64'(4'b0001));
    memReady_i = 1'b0;
    repeat (3) begin
      step();
      check("stall_go", 64'(last_go), 64'd0);
    end
`ifdef EXEC_ARB_STALL_CNT_EN
    check("stall_cnt3", 64'(stallCount_o), 64'd3);
`endif
    memReady_i = 1'b1;
    step();
    check("stall_resume", 64'(last_go), 64'(4'b0010));

    // Flush while a record is held. The pointer must not move.
    valid_i = 4'b1000;
    flush_i = 1'b1;
    step();
    check("flush_go", 64'(last_go), 64'd0);
    check("flush_valid", 64'(valid_o), 64'd0);
    flush_i = 1'b0;
    valid_i = 4'b1111;
    step();
    check("flush_rr", 64'(last_go), 64'(4'b0100));

    // Asynchronous reset between edges while a record is held.
    #2;
    reset_i = 1'b0;
    #1;
    check("areset_valid", 64'(valid_o), 64'd0);
    check("areset_data", dataToMem_o, 64'd0);
    check("areset_go", 64'(canGo_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    step();
    check("areset_rr0", 64'(last_go), 64'(4'b0001));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      valid_i    = 4'($urandom);
      memReady_i = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 15) == 0);
      randomize_data();
      step();
    end
    flush_i    = 1'b0;
    memReady_i = 1'b1;
    valid_i    = 4'b0000;
    step();

`ifdef EXEC_ARB_STALL_CNT_EN
    // Long stall: the counter must saturate and not wrap.
    valid_i = 4'b0001;
    step();
    valid_i    = 4'b0000;
    memReady_i = 1'b0;
    repeat (70000) @(posedge clk_i);
    #1;
    check("sat_cnt", 64'(stallCount_o), 64'hFFFF);
    check("sat_valid", 64'(valid_o), 64'd1);
    m_sc = 16'hFFFF;
    step();
    memReady_i = 1'b1;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_output_arbiter.md
EXEC_OUTPUT_ARBITER -- requirements
Module: exec_output_arbiter

Interface
REQ-001 SHALL have parameter ROBsize, default 8, ROB entry count.
REQ-002 SHALL have parameter ROBsizeLog, default $clog2(ROBsize+1), tag width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_i  input  [3:0]  per-execution-unit result valid.
REQ-006 SHALL have port executeVal_i  input  [3:0][63:0]  per-unit result data.
REQ-007 SHALL have port executeCommands_i  input  [3:0][9:0]  per-unit command bits.
REQ-008 SHALL have port executeTag_i  input  [3:0][ROBsizeLog-1:0]  per-unit ROB tag.
REQ-009 SHALL have port executeFlags_i  input  [3:0][3:0]  per-unit flags.
REQ-010 SHALL have port canGo_o  output  [3:0]  one-hot grant; unit k's result is accepted this cycle.
REQ-011 SHALL have port memReady_i  input  1  memory stage accepts the held result this cycle.
REQ-012 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-013 SHALL have ports dataToMem_o [63:0], commandsToMem_o [9:0], tagToMem_o [ROBsizeLog-1:0], flagsToMem_o [3:0], all outputs, registered record to memory.
REQ-014 SHALL have port valid_o  output  1  output register holds a valid record.

Function
REQ-015 SHALL contain a one-entry output register (record plus valid_o) and a 2-bit round-robin pointer rrPtr.
REQ-016 SHALL define loadOk = (!valid_o || memReady_i) && !flush_i.
REQ-017 SHALL, when loadOk and valid_i != 0, assert exactly one canGo_o bit: the first set valid_i bit scanning rrPtr, rrPtr+1, ... mod 4; otherwise canGo_o = 0.
REQ-018 SHALL drive canGo_o combinationally from valid_i, rrPtr, valid_o, memReady_i, flush_i; no dependency on data inputs.
REQ-019 SHALL, on a grant to unit k, load unit k's val/commands/tag/flags into the output register and set valid_o = 1 at the next edge (1-cycle latency).
REQ-020 SHALL, on a grant to unit k, set rrPtr = (k+1) mod 4 at the next edge; rrPtr holds when no grant.
REQ-021 SHALL, when valid_o && memReady_i and no grant, clear valid_o and all record fields to 0 at the next edge.
REQ-022 SHALL support back-to-back transfers: valid_o && memReady_i with a grant replaces the record in the same edge (full throughput, 1 record/cycle).
REQ-023 SHALL hold the record stable while valid_o && !memReady_i, with canGo_o = 0.
REQ-024 SHALL drive all record outputs to 0 whenever valid_o = 0.
REQ-025 SHALL, on flush_i = 1, force canGo_o = 0 that cycle and clear valid_o and record fields at the next edge; rrPtr unchanged; flush overrides memReady_i and valid_i.
REQ-026 SHALL grant any continuously valid requester within 4 consecutive grants (starvation-free).
REQ-027 SHALL rely on requesters holding valid_i and data stable until their canGo_o bit is seen; unaccepted requests are not stored.

Reset
REQ-028 SHALL, while reset_i = 0, immediately set valid_o = 0, all record outputs = 0, rrPtr = 0, canGo_o = 0.
REQ-029 SHALL discard any held record if reset asserts mid-transfer; first grant after release scans from unit 0.

Configuration
REQ-030 SHALL, with macro EXEC_ARB_STALL_CNT_EN defined, add output stallCount_o [15:0] counting cycles with valid_o && !memReady_i, saturating at 16'hFFFF, cleared by reset and flush_i.
REQ-031 SHALL, without EXEC_ARB_STALL_CNT_EN, omit stallCount_o and its counter; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset release, valid_i=4'b1111 held, memReady_i=1 -> canGo_o 0001,0010,0100,1000,0001 on successive cycles; tags follow one cycle later.
REQ-033 SHALL cover: valid_i=4'b0100, executeVal_i[2]=64'hDEAD_BEEF, memReady_i=1 -> canGo_o=0100, next cycle valid_o=1, dataToMem_o=64'hDEAD_BEEF, then valid_o=0, data 0.
REQ-034 SHALL cover: valid_o=1, memReady_i=0 for 3 cycles with valid_i=4'b0011 -> canGo_o=0 and record stable 3 cycles; stallCount_o=3 when macro on; grant resumes when memReady_i=1.
REQ-035 SHALL cover: valid_o=1, flush_i=1 with valid_i=4'b1000 -> canGo_o=0, next cycle valid_o=0, rrPtr unchanged.
REQ-036 SHALL cover: reset_i driven low between clock edges while valid_o=1 -> valid_o=0 and rrPtr=0 immediately, without waiting for a clock edge.
REQ-037 SHALL cover: stall counter held 70000 cycles with macro on -> stallCount_o=16'hFFFF, no wrap.
